turf_cmd_serializer: RTL and testbench

TURF_CMD_SERIALIZER -- requirements
Module: turf_cmd_serializer

---
 rtl/turf_cmd_serializer.sv | 132 +++++++++++++
 tb/tb_turf_cmd_serializer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/turf_cmd_serializer.sv
// turf_cmd_serializer
//   Serializes one trigger command per accept into a fixed-length frame that
//   is broadcast on one serial CMD line per SURF:
//     start bit (1), buffer[1:0] MSB first, evid[31:0] MSB first, parity.
//   The parity bit is the XOR of the 34 buffer/evid bits, so the data bits
//   plus the parity bit always carry an even number of ones.
//   A frame is followed by GUARD idle cycles before the next accept.
//
// Ports
//   clk33_i        sole clock, rising edge
//   rst_i          synchronous, active-high reset
//   cmd_valid_i    command offered by the trigger logic
//   cmd_ready_o    high only while idle; an accept is valid & ready
//   evid_i         event ID, captured on accept
//   buffer_i       SURF hold-buffer number, captured on accept
//   surf_mask_i    1 = lane disabled for this frame, captured on accept
//   cmd_o          registered serial command line per SURF
//   frame_done_o   one-cycle pulse while the parity bit is on cmd_o
//   frame_count_o  completed-frame counter, wraps at 16 bits
module turf_cmd_serializer #(
    parameter int NUM_SURFS = 12,
    parameter int GUARD     = 4
) (
    input  logic                 clk33_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [31:0]          evid_i,
    input  logic [1:0]           buffer_i,
    input  logic [NUM_SURFS-1:0] surf_mask_i,
    output logic [NUM_SURFS-1:0] cmd_o,
    output logic                 frame_done_o,
    output logic [15:0]          frame_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BUF,
        ST_EVID,
        ST_PARITY,
        ST_GUARD
    } state_t;

    state_t               state;
    logic [4:0]           cnt;
    logic [33:0]          shreg;    // {buffer, evid}; bit 33 is the next bit out
    logic                 par;
    logic [NUM_SURFS-1:0] lane_en;  // inverted mask captured at accept

    // Ready is a pure function of state so it never depends on cmd_valid_i.
    assign cmd_ready_o = (state == ST_IDLE);

    // Replicate one frame bit onto every enabled lane; disabled lanes stay 0.
    function automatic logic [NUM_SURFS-1:0] drive_lanes(
        input logic                 bit_val,
        input logic [NUM_SURFS-1:0] en
    );
        return en & {NUM_SURFS{bit_val}};
    endfunction

    // cmd_o is loaded with the bit belonging to the state being entered, so
    // the line value and the state always change on the same edge.
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            cmd_o         <= '0;
            frame_done_o  <= 1'b0;
            frame_count_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        state   <= ST_START;
                        shreg   <= {buffer_i, evid_i};
                        par     <= ^{buffer_i, evid_i};
                        lane_en <= ~surf_mask_i;
                        cmd_o   <= ~surf_mask_i;  // start bit
                    end
                end
                ST_START: begin
                    state <= ST_BUF;
                    cnt   <= '0;
                    cmd_o <= drive_lanes(shreg[33], lane_en);
                    shreg <= {shreg[32:0], 1'b0};
                end
                ST_BUF: begin
                    cmd_o <= drive_lanes(shreg[33], lane_en);
                    shreg <= {shreg[32:0], 1'b0};
                    if (cnt == 5'd1) begin
                        state <= ST_EVID;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_EVID: begin
                    // The last evid bit is already on the line; load parity next.
                    if (cnt == 5'd31) begin
                        state        <= ST_PARITY;
                        cmd_o        <= drive_lanes(par, lane_en);
                        frame_done_o <= 1'b1;
                    end else begin
                        cmd_o <= drive_lanes(shreg[33], lane_en);
                        shreg <= {shreg[32:0], 1'b0};
                        cnt   <= cnt + 5'd1;
                    end
                end
                ST_PARITY: begin
                    state         <= ST_GUARD;
                    cnt           <= '0;
                    cmd_o         <= '0;
                    frame_done_o  <= 1'b0;
                    frame_count_o <= frame_count_o + 16'd1;
                end
                ST_GUARD: begin
                    if (cnt == 5'(GUARD - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cmd_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turf_cmd_serializer.sv
// Directed bench for turf_cmd_serializer (NUM_SURFS=12, GUARD=4).
// Inputs are driven at the falling edge; outputs are sampled at the falling
// edge, half a period away from the active rising edge.
module tb_turf_cmd_serializer;

    localparam int NS = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   evid;
    logic [1:0]    buffer;
    logic [NS-1:0] surf_mask;
    logic [NS-1:0] cmd;
    logic          frame_done;
    logic [15:0]   frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    turf_cmd_serializer #(.NUM_SURFS(NS), .GUARD(4)) dut (
        .clk33_i       (clk),
        .rst_i         (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .evid_i        (evid),
        .buffer_i      (buffer),
        .surf_mask_i   (surf_mask),
        .cmd_o         (cmd),
        .frame_done_o  (frame_done),
        .frame_count_o (frame_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one frame from an idle falling edge and check every cycle of it
    // through the guard interval. exp_par is the hand-computed parity bit.
    task automatic send_frame(input string tag, input logic [31:0] ev, input logic [1:0] bf,
                              input logic [NS-1:0] mk, input logic exp_par,
                              input bit scramble, input logic [15:0] exp_cnt);
        logic [35:0]   bits;
        logic [NS-1:0] lanes;
        bits = {1'b1, bf, ev, exp_par};
        chk({tag, ".ready_idle"}, cmd_ready, 1);
        evid = ev; buffer = bf; surf_mask = mk; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 36; k++) begin   // cycles T+1 .. T+36
            lanes = bits[35-k] ? ~mk : '0;
            chk($sformatf("%s.cmd%0d", tag, k), cmd, lanes);
            chk($sformatf("%s.done%0d", tag, k), frame_done, (k == 35));
            chk($sformatf("%s.busy%0d", tag, k), cmd_ready, 0);
            if (scramble) begin
                evid = $urandom; buffer = 2'($urandom); surf_mask = NS'($urandom);
            end
            @(negedge clk);
        end
        chk({tag, ".count"}, frame_count, exp_cnt);
        for (int g = 0; g < 4; g++) begin    // guard cycles T+37 .. T+40
            chk($sformatf("%s.guard_cmd%0d", tag, g), cmd, 0);
            chk($sformatf("%s.guard_busy%0d", tag, g), cmd_ready, 0);
            @(negedge clk);
        end
        chk({tag, ".ready_back"}, cmd_ready, 1);  // T+41
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[$];
        int n_ready;
        bool_wait: begin end
        rst = 1'b1; cmd_valid = 1'b0; evid = '0; buffer = '0; surf_mask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.cmd", cmd, 0);
        chk("rst.done", frame_done, 0);
        chk("rst.count", frame_count, 0);
        chk("rst.ready", cmd_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Reset at T+20 aborts the frame with no pulse and no count.
        evid = 32'hFFFF_FFFF; buffer = 2'b11; surf_mask = '0; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);                 // T+1
        cmd_valid = 1'b0;
        chk("abort.start", cmd, 12'hFFF);
        for (int k = 1; k < 20; k++) begin
            chk($sformatf("abort.done%0d", k), frame_done, 0);
            @(negedge clk);
        end                             // now T+20
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);                 // T+21
        rst = 1'b0;
        chk("abort.cmd", cmd, 0);
        chk("abort.ready", cmd_ready, 1);
        chk("abort.done", frame_done, 0);
        chk("abort.count", frame_count, 0);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("abort.quiet%0d", k), {frame_done, cmd}, 0);
            @(negedge clk);
        end

        // 1,1,0, 31 zeros, 1, parity 0 on every lane.
        send_frame("f1", 32'h0000_0001, 2'b10, 12'h000, 1'b0, 1'b0, 16'd1);
        // Lane 0 masked, parity 1 (17 ones in data).
        send_frame("f2", 32'hA5A5_A5A5, 2'b01, 12'h001, 1'b1, 1'b0, 16'd2);
        // Inputs scrambled every cycle after accept; 15 ones in data -> parity 1.
        send_frame("f3", 32'h1234_5678, 2'b11, 12'h800, 1'b1, 1'b1, 16'd3);
        // All lanes masked: same timing, all-zero lines, still counts.
        send_frame("f4", 32'hDEAD_BEEF, 2'b00, 12'hFFF, 1'b0, 1'b0, 16'd4);

        // Reset wins over an accept in the same cycle.
        evid = 32'h5555_0000; buffer = 2'b10; surf_mask = '0;
        cmd_valid = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        chk("rstacc.count", frame_count, 0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rstacc.cmd%0d", k), cmd, 0);
            chk($sformatf("rstacc.ready%0d", k), cmd_ready, 1);
            @(negedge clk);
        end

        // cmd_valid held high: accepts exactly every 41 cycles.
        evid = 32'hCAFE_F00D; buffer = 2'b01; surf_mask = '0; cmd_valid = 1'b1;
        n_ready = 0;
        for (int c = 0; c < 125; c++) begin
            if (cmd_ready) begin
                acc.push_back(c);
                n_ready++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("stream.n_accepts", acc.size(), 4);
        chk("stream.n_ready", n_ready, 4);
        for (int i = 0; i < acc.size(); i++)
            chk($sformatf("stream.accept%0d", i), acc[i], 41 * i);
        for (int w = 0; w < 60 && !cmd_ready; w++) @(negedge clk);
        chk("stream.idle", cmd_ready, 1);
        chk("stream.count", frame_count, 4);

        // Preload the counter to 0xFFFF, then one frame wraps it to 0.
        force dut.frame_count_o = 16'hFFFF;
        #1;
        release dut.frame_count_o;
        chk("wrap.preload", frame_count, 16'hFFFF);
        send_frame("wrap", 32'h0000_0000, 2'b00, 12'h000, 1'b0, 1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
